// File: rtl/router_register_param.sv
// Router packet datapath register. It captures the header and forwards the header, payload and
// parity words to the destination FIFO. A small hold buffer absorbs words that arrive while the
// FIFO is full. It checks packet parity and payload length against the header length field.
module router_register_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned HOLD_DEPTH = 2,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_pkt_valid,
  input  logic [DATA_W-1:0]                 i_data_in,
  input  logic                              i_fifo_full,
  input  logic                              i_detect_add,
  input  logic                              i_lfd_state,
  input  logic                              i_ld_state,
  input  logic                              i_laf_state,
  input  logic                              i_full_state,
  input  logic                              i_rst_int_reg,
  output logic [DATA_W-1:0]                 o_dout,
  output logic                              o_dout_valid,
  output logic                              o_parity_done,
  output logic                              o_low_packet_valid,
  output logic                              o_err,
  output logic                              o_len_err,
  output logic                              o_ovf_err,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]   o_hold_count
);

  localparam int unsigned LEN_W = DATA_W - ADDR_W;
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int unsigned HC_W  = $clog2(HOLD_DEPTH + 1);

  logic [DATA_W-1:0] r_header, r_int_parity, r_pkt_parity, r_dout;
  logic [CNT_W-1:0]  r_pay_cnt;
  logic              r_dout_valid, r_parity_done, r_low_pkt_valid, r_err, r_len_err, r_ovf_err;
  logic [DATA_W-1:0] r_hold_mem [0:(1<<PTR_W)-1];
  logic [PTR_W-1:0]  r_rd_ptr, r_wr_ptr;
  logic [HC_W-1:0]   r_hold_cnt;

  logic              w_hdr_ok, w_payload, w_parity_word;
  logic              w_hold_empty, w_hold_full, w_pop, w_push_req, w_push_ok, w_ovf;
  logic              w_parity_done_nxt;
  logic [LEN_W-1:0]  w_len;
  logic [DATA_W-1:0] w_exp_parity;

  assign w_hdr_ok      = i_detect_add & i_pkt_valid &
                         (i_data_in[ADDR_W-1:0] != {ADDR_W{1'b1}});
  assign w_payload     = i_ld_state & i_pkt_valid & ~i_full_state;
  assign w_parity_word = i_ld_state & ~i_pkt_valid;
  assign w_len         = r_header[DATA_W-1:ADDR_W];
  assign w_exp_parity  = PARITY_ODD ? ~r_int_parity : r_int_parity;

  assign w_hold_empty = (r_hold_cnt == '0);
  assign w_hold_full  = (r_hold_cnt == HC_W'(HOLD_DEPTH));
  assign w_pop        = (i_ld_state | i_laf_state) & ~i_fifo_full & ~w_hold_empty;
  // Once the buffer holds anything, every new ld word must queue behind it to keep order.
  assign w_push_req   = i_ld_state & (i_fifo_full | ~w_hold_empty);
  assign w_push_ok    = w_push_req & (~w_hold_full | w_pop);
  assign w_ovf        = w_push_req & w_hold_full & ~w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(HOLD_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next value of parity_done, shared with err so err drops together with parity_done.
  always_comb begin
    w_parity_done_nxt = r_parity_done;
    if (i_detect_add) begin
      w_parity_done_nxt = 1'b0;
    end else if ((w_parity_word & ~i_fifo_full) |
                 (i_laf_state & r_low_pkt_valid & ~r_parity_done)) begin
      w_parity_done_nxt = 1'b1;
    end
  end

  // Header capture; addresses with all-ones destination are ignored.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_header <= '0;
    end else if (w_hdr_ok) begin
      r_header <= i_data_in;
    end
  end

  // Output word and FIFO write strobe.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= 1'b0;
      if (i_lfd_state) begin
        r_dout       <= r_header;
        r_dout_valid <= 1'b1;
      end else if (w_pop) begin
        r_dout       <= r_hold_mem[r_rd_ptr];
        r_dout_valid <= 1'b1;
      end else if (i_ld_state & ~i_fifo_full) begin
        r_dout       <= i_data_in;
        r_dout_valid <= 1'b1;
      end
    end
  end

  // Hold buffer storage; occupancy is tracked separately, so no reset is needed here.
  always_ff @(posedge i_clock) begin
    if (w_push_ok) begin
      r_hold_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // Hold buffer pointers and occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push_ok & ~w_pop)      r_hold_cnt <= r_hold_cnt + 1'b1;
      else if (w_pop & ~w_push_ok) r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // Running parity and payload word count for the current packet.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_int_parity <= '0;
      r_pay_cnt    <= '0;
    end else if (i_detect_add) begin
      r_int_parity <= '0;
      r_pay_cnt    <= '0;
    end else if (i_lfd_state) begin
      r_int_parity <= r_int_parity ^ r_header;
    end else if (w_payload) begin
      r_int_parity <= r_int_parity ^ i_data_in;
      if (r_pay_cnt != {CNT_W{1'b1}}) r_pay_cnt <= r_pay_cnt + 1'b1;
    end
  end

  // Parity word capture and per-packet status flags.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pkt_parity    <= '0;
      r_low_pkt_valid <= 1'b0;
      r_len_err       <= 1'b0;
      r_ovf_err       <= 1'b0;
      r_parity_done   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_parity_done <= w_parity_done_nxt;
      // Gating on the current parity_done delays err by one cycle after parity_done rises.
      r_err         <= w_parity_done_nxt & r_parity_done & (r_pkt_parity != w_exp_parity);
      if (w_parity_word) begin
        r_pkt_parity <= i_data_in;
        r_len_err    <= (r_pay_cnt != {1'b0, w_len});
      end else if (i_detect_add) begin
        r_len_err <= 1'b0;
      end
      if (i_rst_int_reg)      r_low_pkt_valid <= 1'b0;
      else if (w_parity_word) r_low_pkt_valid <= 1'b1;
      if (i_detect_add) r_ovf_err <= 1'b0;
      else if (w_ovf)   r_ovf_err <= 1'b1;
    end
  end

  assign o_dout             = r_dout;
  assign o_dout_valid       = r_dout_valid;
  assign o_parity_done      = r_parity_done;
  assign o_low_packet_valid = r_low_pkt_valid;
  assign o_err              = r_err;
  assign o_len_err          = r_len_err;
  assign o_ovf_err          = r_ovf_err;
  assign o_hold_count       = r_hold_cnt;

endmodule

// File: tb/tb_router_register_param.sv
// Directed bench for router_register_param: three instances (default, one-entry hold buffer,
// odd parity) share one stimulus stream; FIFO-bound words of the default instance are
// checked against a queue of expected words.
module tb_router_register_param;

  logic       clk, rst, pv, ff, da, lfd, ld, laf, fs, rir;
  logic [7:0] din;

  logic [7:0] d0_dout, d1_dout, d2_dout;
  logic       d0_v, d0_pd, d0_lpv, d0_err, d0_len, d0_ovf;
  logic       d1_v, d1_pd, d1_lpv, d1_err, d1_len, d1_ovf;
  logic       d2_v, d2_pd, d2_lpv, d2_err, d2_len, d2_ovf;
  logic [1:0] d0_hc, d2_hc;
  logic       d1_hc;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  router_register_param #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(2), .PARITY_ODD(1'b0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_pkt_valid(pv), .i_data_in(din), .i_fifo_full(ff),
    .i_detect_add(da), .i_lfd_state(lfd), .i_ld_state(ld), .i_laf_state(laf),
    .i_full_state(fs), .i_rst_int_reg(rir), .o_dout(d0_dout), .o_dout_valid(d0_v),
    .o_parity_done(d0_pd), .o_low_packet_valid(d0_lpv), .o_err(d0_err), .o_len_err(d0_len),
    .o_ovf_err(d0_ovf), .o_hold_count(d0_hc));

  router_register_param #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(1), .PARITY_ODD(1'b0)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_pkt_valid(pv), .i_data_in(din), .i_fifo_full(ff),
    .i_detect_add(da), .i_lfd_state(lfd), .i_ld_state(ld), .i_laf_state(laf),
    .i_full_state(fs), .i_rst_int_reg(rir), .o_dout(d1_dout), .o_dout_valid(d1_v),
    .o_parity_done(d1_pd), .o_low_packet_valid(d1_lpv), .o_err(d1_err), .o_len_err(d1_len),
    .o_ovf_err(d1_ovf), .o_hold_count(d1_hc));

  router_register_param #(.DATA_W(8), .ADDR_W(2), .HOLD_DEPTH(2), .PARITY_ODD(1'b1)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_pkt_valid(pv), .i_data_in(din), .i_fifo_full(ff),
    .i_detect_add(da), .i_lfd_state(lfd), .i_ld_state(ld), .i_laf_state(laf),
    .i_full_state(fs), .i_rst_int_reg(rir), .o_dout(d2_dout), .o_dout_valid(d2_v),
    .o_parity_done(d2_pd), .o_low_packet_valid(d2_lpv), .o_err(d2_err), .o_len_err(d2_len),
    .o_ovf_err(d2_ovf), .o_hold_count(d2_hc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge and score any FIFO write from instance 0.
  task automatic tick();
    @(posedge clk);
    #1;
    if (d0_v === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL dout_extra observed=%0h expected=none", d0_dout);
      end else begin
        chk("dout", {24'h0, d0_dout}, {24'h0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic idle();
    da = 0; lfd = 0; ld = 0; laf = 0; fs = 0; rir = 0; ff = 0; pv = 0; din = 8'h00;
  endtask

  // Header, three payload words and parity with the FIFO never full.
  task automatic pkt3(input logic [7:0] h, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] par);
    idle(); da = 1; pv = 1; din = h; tick();
    da = 0; lfd = 1; exp_q.push_back(h); tick();
    lfd = 0; ld = 1;
    din = a; exp_q.push_back(a); tick();
    din = b; exp_q.push_back(b); tick();
    din = c; exp_q.push_back(c); tick();
    pv = 0; din = par; exp_q.push_back(par); tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_dout", {24'h0, d0_dout}, 0);
    chk("rst_valid", {31'h0, d0_v}, 0);
    chk("rst_pd", {31'h0, d0_pd}, 0);
    chk("rst_lpv", {31'h0, d0_lpv}, 0);
    chk("rst_err", {31'h0, d0_err}, 0);
    chk("rst_len", {31'h0, d0_len}, 0);
    chk("rst_ovf", {31'h0, d0_ovf}, 0);
    chk("rst_hold", {30'h0, d0_hc}, 0);
    rst = 0;

    // Good packet: even parity matches, odd-parity instance flags an error.
    pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    chk("p1_pd", {31'h0, d0_pd}, 1);
    chk("p1_lpv", {31'h0, d0_lpv}, 1);
    chk("p1_len", {31'h0, d0_len}, 0);
    idle(); rir = 1; tick();
    chk("p1_err", {31'h0, d0_err}, 0);
    chk("p1_lpv_clr", {31'h0, d0_lpv}, 0);
    chk("p1_odd_err", {31'h0, d2_err}, 1);

    // Bad parity: err rises one cycle after parity_done, drops on detect_add.
    pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C);
    chk("p2_pd", {31'h0, d0_pd}, 1);
    chk("p2_err_early", {31'h0, d0_err}, 0);
    idle(); rir = 1; tick();
    chk("p2_err", {31'h0, d0_err}, 1);
    idle(); da = 1; pv = 1; din = 8'h0D; tick();
    chk("p2_err_clr", {31'h0, d0_err}, 0);
    chk("p2_pd_clr", {31'h0, d0_pd}, 0);
    chk("p2_odd_err_clr", {31'h0, d2_err}, 0);

    // Inverted parity word: correct for odd sense only.
    pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'hF2);
    idle(); rir = 1; tick();
    chk("p3_err", {31'h0, d0_err}, 1);
    chk("p3_odd_err", {31'h0, d2_err}, 0);

    // Length mismatch (L=4, three words); parity word parked in hold, done via laf path.
    idle(); da = 1; pv = 1; din = 8'h11; tick();
    da = 0; lfd = 1; exp_q.push_back(8'h11); tick();
    lfd = 0; ld = 1;
    din = 8'h01; exp_q.push_back(8'h01); tick();
    din = 8'h02; exp_q.push_back(8'h02); tick();
    din = 8'h04; exp_q.push_back(8'h04); tick();
    pv = 0; ff = 1; din = 8'h16; tick();
    chk("p4_hold", {30'h0, d0_hc}, 1);
    chk("p4_pd_wait", {31'h0, d0_pd}, 0);
    chk("p4_len", {31'h0, d0_len}, 1);
    idle(); laf = 1; exp_q.push_back(8'h16); tick();
    chk("p4_pd_laf", {31'h0, d0_pd}, 1);
    chk("p4_hold_empty", {30'h0, d0_hc}, 0);
    idle(); rir = 1; tick();
    chk("p4_err", {31'h0, d0_err}, 0);
    chk("p4_len_hold", {31'h0, d0_len}, 1);

    // Hold buffer: two words while full; depth 1 drops the second.
    idle(); da = 1; pv = 1; din = 8'h0D; tick();
    chk("p5_len_clr", {31'h0, d0_len}, 0);
    da = 0; lfd = 1; exp_q.push_back(8'h0D); tick();
    lfd = 0; ld = 1; din = 8'h11; exp_q.push_back(8'h11); tick();
    ff = 1; din = 8'h22; tick();
    chk("p5_hold1", {30'h0, d0_hc}, 1);
    chk("p5_d1_hold1", {31'h0, d1_hc}, 1);
    din = 8'h33; tick();
    chk("p5_hold2", {30'h0, d0_hc}, 2);
    chk("p5_ovf", {31'h0, d0_ovf}, 0);
    chk("p5_d1_hold", {31'h0, d1_hc}, 1);
    chk("p5_d1_ovf", {31'h0, d1_ovf}, 1);
    idle(); laf = 1; exp_q.push_back(8'h22); tick();
    chk("p5_drain1", {30'h0, d0_hc}, 1);
    chk("p5_d1_dout", {23'h0, d1_v, d1_dout}, {23'h0, 1'b1, 8'h22});
    exp_q.push_back(8'h33); tick();
    chk("p5_drain2", {30'h0, d0_hc}, 0);
    chk("p5_d1_novalid", {31'h0, d1_v}, 0);
    idle(); ld = 1; pv = 0; din = 8'h0D; exp_q.push_back(8'h0D); tick();
    chk("p5_pd", {31'h0, d0_pd}, 1);
    chk("p5_len", {31'h0, d0_len}, 0);
    idle(); rir = 1; tick();
    chk("p5_err", {31'h0, d0_err}, 0);

    // Invalid destination: header register keeps 0x0D.
    idle(); da = 1; pv = 1; din = 8'h03; tick();
    da = 0; lfd = 1; exp_q.push_back(8'h0D); tick();
    idle(); tick();

    // Reset mid-payload with a word in the hold buffer.
    idle(); da = 1; pv = 1; din = 8'h15; tick();
    da = 0; lfd = 1; exp_q.push_back(8'h15); tick();
    lfd = 0; ld = 1; din = 8'h01; exp_q.push_back(8'h01); tick();
    ff = 1; din = 8'h02; tick();
    chk("p7_hold_pre", {30'h0, d0_hc}, 1);
    rst = 1; tick();
    chk("p7_dout", {23'h0, d0_v, d0_dout}, 0);
    chk("p7_flags", {26'h0, d0_pd, d0_lpv, d0_err, d0_len, d0_ovf, 1'b0}, 0);
    chk("p7_hold", {30'h0, d0_hc}, 0);
    chk("p7_d1_hold", {31'h0, d1_hc}, 0);
    rst = 0; idle(); tick();
    pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    chk("p8_pd", {31'h0, d0_pd}, 1);
    chk("p8_len", {31'h0, d0_len}, 0);
    idle(); rir = 1; tick();
    chk("p8_err", {31'h0, d0_err}, 0);
    chk("p8_hold", {30'h0, d0_hc}, 0);
    idle(); tick();
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
